// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count-enable control stage and its downstream counter bench.
`default_nettype none

package count_ctrl_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DIV_W_DEF       = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage : count_ctrl_pkg

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// Push-button synchroniser with rising-edge detect; flops reset high so a held button gives no event.
`default_nettype none

module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : btn_sync_edge

`default_nettype wire

// File: rtl/count_enable_gen.sv
// Count-enable generator: start/stop/step buttons drive an IDLE/RUN FSM and a prescaler emitting one-cycle ticks.
`default_nettype none

module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             running
);

  logic start_evt, stop_evt, step_evt;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .reset(reset), .btn_i(start), .evt_o(start_evt)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
    .clk(clk), .reset(reset), .btn_i(stop), .evt_o(stop_evt)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .reset(reset), .btn_i(step), .evt_o(step_evt)
  );

  ctrl_state_e      state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] div_eff_m1;

  assign div_eff_m1 = (div == '0) ? '0 : div - DIV_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!stop_evt && start_evt) state_d = ST_RUN;
      ST_RUN:  if (stop_evt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The prescaler counts down to 0 (tick on arrival) and reloads on the following cycle,
  // which gives a tick period of exactly div_eff and a first tick div_eff-1 cycles after entry.
  always_comb begin
    presc_d   = presc_q;
    tick_d    = 1'b0;
    running_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop_evt) begin
          if (start_evt) begin
            presc_d   = div_eff_m1;
            tick_d    = (div_eff_m1 == '0);
            running_d = 1'b1;
          end else if (step_evt) begin
            tick_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_evt) begin
          presc_d = '0;
        end else begin
          running_d = 1'b1;
          if (presc_q == '0) begin
            presc_d = div_eff_m1;
            tick_d  = (div_eff_m1 == '0);
          end else begin
            presc_d = presc_q - DIV_W'(1);
            tick_d  = (presc_q == DIV_W'(1));
          end
        end
      end
      default: presc_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign tick    = tick_q;
  assign running = running_q;

endmodule : count_enable_gen

`default_nettype wire

// File: tb/tb_count_enable_gen.sv
// Directed self-checking bench for count_enable_gen.
`default_nettype none

module tb_count_enable_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic [7:0] div = 8'd4;
  logic       tick;
  logic       running;

  int total = 0;
  int bad   = 0;

  count_enable_gen #(.DIV_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .div(div), .tick(tick), .running(running)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; stop = 1'b0; step = 1'b0; div = 8'd4;
    cyc(2);
    total++;
    if ({running, tick} !== 2'b00) begin
      bad++; $display("FAIL reset_values: running,tick=%b expected 00", {running, tick});
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      total++;
      if ({running, tick} !== 2'b00) begin
        bad++; $display("FAIL held_start_no_event cyc%0d: running,tick=%b expected 00", i, {running, tick});
      end
    end
    start = 1'b0;
    cyc(4);
  endtask

  task automatic test_div4();
    int nt;
    div = 8'd4; start = 1'b1;
    cyc(2);
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL start_latency_early: running=%b expected 0", running);
    end
    cyc(1);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL start_latency: running=%b expected 1", running);
    end
    start = 1'b0;
    nt = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (tick === 1'b1) nt++;
      total++;
      if (tick !== ((k % 4) == 3)) begin
        bad++; $display("FAIL div4_tick R+%0d: tick=%b expected %b", k, tick, (k % 4) == 3);
      end
    end
    total++;
    if (nt != 5) begin
      bad++; $display("FAIL div4_tick_count: got %0d expected 5", nt);
    end
    stop = 1'b1;
    cyc(3);
    total++;
    if ({running, tick} !== 2'b00) begin
      bad++; $display("FAIL div4_stop: running,tick=%b expected 00", {running, tick});
    end
    stop = 1'b0;
    cyc(4);
  endtask

  task automatic test_div0();
    div = 8'd0; start = 1'b1;
    cyc(3);
    total++;
    if ({running, tick} !== 2'b11) begin
      bad++; $display("FAIL div0_entry: running,tick=%b expected 11", {running, tick});
    end
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      total++;
      if ({running, tick} !== 2'b11) begin
        bad++; $display("FAIL div0_every_cycle R+%0d: running,tick=%b expected 11", k, {running, tick});
      end
    end
    stop = 1'b1;
    cyc(2);
    total++;
    if ({running, tick} !== 2'b11) begin
      bad++; $display("FAIL div0_stop_early: running,tick=%b expected 11", {running, tick});
    end
    cyc(1);
    total++;
    if ({running, tick} !== 2'b00) begin
      bad++; $display("FAIL div0_stop: running,tick=%b expected 00", {running, tick});
    end
    stop = 1'b0;
    cyc(4);
  endtask

  task automatic test_step();
    int nt;
    nt = 0;
    div = 8'd4;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc(2);
      total++;
      if (tick !== 1'b0) begin
        bad++; $display("FAIL step%0d_early: tick=%b expected 0", p, tick);
      end
      step = 1'b0;
      cyc(1);
      if (tick === 1'b1) nt++;
      total++;
      if (tick !== 1'b1) begin
        bad++; $display("FAIL step%0d_tick: tick=%b expected 1", p, tick);
      end
      for (int j = 0; j < 4; j++) begin
        cyc(1);
        if (tick === 1'b1) nt++;
      end
    end
    total++;
    if (nt != 3) begin
      bad++; $display("FAIL step_tick_count: got %0d expected 3", nt);
    end
    div = 8'd10; start = 1'b1;
    cyc(3);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL div10_start: running=%b expected 1", running);
    end
    start = 1'b0;
    nt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) step = 1'b1;
      if (k == 4) step = 1'b0;
      cyc(1);
      if (tick === 1'b1) nt++;
      total++;
      if (tick !== ((k % 10) == 9)) begin
        bad++; $display("FAIL div10_tick R+%0d: tick=%b expected %b", k, tick, (k % 10) == 9);
      end
    end
    total++;
    if (nt != 3) begin
      bad++; $display("FAIL run_step_ignored: ticks=%0d expected 3", nt);
    end
    stop = 1'b1;
    cyc(3);
    total++;
    if ({running, tick} !== 2'b00) begin
      bad++; $display("FAIL div10_stop: running,tick=%b expected 00", {running, tick});
    end
    stop = 1'b0;
    cyc(4);
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      total++;
      if ({running, tick} !== 2'b00) begin
        bad++; $display("FAIL start_stop_same cyc%0d: running,tick=%b expected 00", k, {running, tick});
      end
    end
    start = 1'b0; stop = 1'b0;
    cyc(4);
    div = 8'd4; start = 1'b1;
    cyc(3);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL stopzero_start: running=%b expected 1", running);
    end
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) stop = 1'b1;
      cyc(1);
      total++;
      if ({running, tick} !== {(k < 7), (k == 3)}) begin
        bad++; $display("FAIL stop_at_zero R+%0d: running,tick=%b expected %b", k, {running, tick}, {(k < 7), (k == 3)});
      end
    end
    stop = 1'b0;
    cyc(4);
  endtask

  task automatic test_async_reset();
    div = 8'd4; start = 1'b1;
    cyc(3);
    start = 1'b0;
    cyc(3);
    total++;
    if ({running, tick} !== 2'b11) begin
      bad++; $display("FAIL pre_reset_tick: running,tick=%b expected 11", {running, tick});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({running, tick} !== 2'b00) begin
      bad++; $display("FAIL async_reset: running,tick=%b expected 00", {running, tick});
    end
    #2 reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      total++;
      if ({running, tick} !== 2'b00) begin
        bad++; $display("FAIL post_reset_idle cyc%0d: running,tick=%b expected 00", k, {running, tick});
      end
    end
    start = 1'b1;
    cyc(3);
    total++;
    if (running !== 1'b1) begin
      bad++; $display("FAIL restart_after_reset: running=%b expected 1", running);
    end
    start = 1'b0; stop = 1'b1;
    cyc(3);
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL final_stop: running=%b expected 0", running);
    end
    stop = 1'b0;
    cyc(4);
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div0();
    test_step();
    test_start_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_enable_gen

`default_nettype wire
